// File: rtl/eth_tx_framer.sv
// Transmit Ethernet framer: wraps a raw frame byte stream with preamble, SFD,
// zero pad and FCS, then holds the line idle for the inter-frame gap.
module eth_tx_framer #(
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic        clk125MHz,
    input  logic        resetn,
    input  logic        tx_adv,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    output logic        busy,
    output logic        underrun,
    output logic        truncated,
    output logic [15:0] frame_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG, FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] count_inc;
    logic [2:0]    pre_count;
    logic [1:0]    fcs_index;
    logic [IW-1:0] ifg_count;
    logic [31:0]   crc;
    logic          bad_fcs;
    logic          flush_pending;
    logic          pad_after_inc;
    logic          pad_now;
    logic          hit_max;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // A frame marked bad sends the raw register so the receiver's check fails.
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic bad,
                                            input logic [1:0] idx);
        logic [31:0] v;
        v = bad ? c : ~c;
        v = v >> {idx, 3'b000};
        return v[7:0];
    endfunction

    assign in_ready      = ((state == PAYLOAD) || (state == FLUSH)) && tx_adv;
    assign count_inc     = byte_count + CW'(1);
    assign pad_after_inc = int'(count_inc) < MIN_LEN;
    assign pad_now       = int'(byte_count) < MIN_LEN;
    assign hit_max       = int'(count_inc) == MAX_LEN;

    always_ff @(posedge clk125MHz or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            byte_count    <= '0;
            pre_count     <= '0;
            fcs_index     <= '0;
            ifg_count     <= '0;
            crc           <= 32'hFFFFFFFF;
            bad_fcs       <= 1'b0;
            flush_pending <= 1'b0;
            tx_data       <= 8'h00;
            tx_enable     <= 1'b0;
            busy          <= 1'b0;
            underrun      <= 1'b0;
            truncated     <= 1'b0;
            frame_count   <= '0;
        end else begin
            underrun  <= 1'b0;
            truncated <= 1'b0;
            if (tx_adv) begin
                case (state)
                    // The starting advance already drives the first preamble byte.
                    IDLE: begin
                        tx_data   <= 8'h00;
                        tx_enable <= 1'b0;
                        if (in_valid) begin
                            tx_data       <= 8'h55;
                            tx_enable     <= 1'b1;
                            byte_count    <= '0;
                            pre_count     <= 3'd1;
                            bad_fcs       <= 1'b0;
                            flush_pending <= 1'b0;
                            busy          <= 1'b1;
                            state         <= PREAMBLE;
                        end
                    end
                    PREAMBLE: begin
                        tx_data   <= 8'h55;
                        pre_count <= pre_count + 3'd1;
                        if (pre_count == 3'd6)
                            state <= SFD;
                    end
                    SFD: begin
                        tx_data   <= 8'hD5;
                        crc       <= 32'hFFFFFFFF;
                        fcs_index <= '0;
                        state     <= PAYLOAD;
                    end
                    PAYLOAD: begin
                        if (in_valid) begin
                            tx_data    <= in_data;
                            crc        <= crc_next(crc, in_data);
                            byte_count <= count_inc;
                            if (in_last) begin
                                state <= pad_after_inc ? PAD : FCS;
                            end else if (hit_max) begin
                                truncated     <= 1'b1;
                                flush_pending <= 1'b1;
                                state         <= FCS;
                            end
                        end else begin
                            // Underrun: this advance becomes the first pad or FCS byte.
                            underrun      <= 1'b1;
                            bad_fcs       <= 1'b1;
                            flush_pending <= 1'b1;
                            if (pad_now) begin
                                tx_data    <= 8'h00;
                                crc        <= crc_next(crc, 8'h00);
                                byte_count <= count_inc;
                                state      <= pad_after_inc ? PAD : FCS;
                            end else begin
                                tx_data   <= fcs_byte(crc, 1'b1, 2'd0);
                                fcs_index <= 2'd1;
                                state     <= FCS;
                            end
                        end
                    end
                    PAD: begin
                        tx_data    <= 8'h00;
                        crc        <= crc_next(crc, 8'h00);
                        byte_count <= count_inc;
                        if (!pad_after_inc)
                            state <= FCS;
                    end
                    FCS: begin
                        tx_data   <= fcs_byte(crc, bad_fcs, fcs_index);
                        fcs_index <= fcs_index + 2'd1;
                        if (fcs_index == 2'd3) begin
                            frame_count <= frame_count + 16'd1;
                            ifg_count   <= '0;
                            state       <= IFG;
                        end
                    end
                    IFG: begin
                        tx_data   <= 8'h00;
                        tx_enable <= 1'b0;
                        ifg_count <= ifg_count + IW'(1);
                        if (ifg_count == IW'(IFG_BYTES - 1)) begin
                            busy  <= flush_pending;
                            state <= flush_pending ? FLUSH : IDLE;
                        end
                    end
                    FLUSH: begin
                        tx_data   <= 8'h00;
                        tx_enable <= 1'b0;
                        if (in_valid && in_last) begin
                            busy          <= 1'b0;
                            flush_pending <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized bench for eth_tx_framer: wire bytes, timing and status pulses are
// compared against a frame-level reference model built from plain queues.
module tb_eth_tx_framer;

    localparam int IFG = 12;
    localparam int MAXL = 1514;

    typedef logic [7:0] byte_q [$];

    logic        clk125MHz = 1'b0;
    logic        resetn, tx_adv, in_valid, in_last, sel0;
    logic [7:0]  in_data;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b, en_a, en_b, busy_a, busy_b;
    logic        under_a, under_b, trunc_a, trunc_b;
    logic [7:0]  data_a, data_b;
    logic [15:0] fc_a, fc_b;
    logic        obs_ready, obs_en, obs_busy, obs_under, obs_trunc;
    logic [7:0]  obs_data;
    logic [15:0] obs_fc;

    always #4 clk125MHz = ~clk125MHz;

    assign valid_a   = in_valid & ~sel0;
    assign valid_b   = in_valid & sel0;
    assign obs_ready = sel0 ? ready_b : ready_a;
    assign obs_en    = sel0 ? en_b    : en_a;
    assign obs_busy  = sel0 ? busy_b  : busy_a;
    assign obs_under = sel0 ? under_b : under_a;
    assign obs_trunc = sel0 ? trunc_b : trunc_a;
    assign obs_data  = sel0 ? data_b  : data_a;
    assign obs_fc    = sel0 ? fc_b    : fc_a;

    eth_tx_framer dut (
        .clk125MHz(clk125MHz), .resetn(resetn), .tx_adv(tx_adv),
        .in_data(in_data), .in_valid(valid_a), .in_last(in_last),
        .in_ready(ready_a), .tx_data(data_a), .tx_enable(en_a), .busy(busy_a),
        .underrun(under_a), .truncated(trunc_a), .frame_count(fc_a)
    );

    eth_tx_framer #(.MIN_LEN(0)) dut_nopad (
        .clk125MHz(clk125MHz), .resetn(resetn), .tx_adv(tx_adv),
        .in_data(in_data), .in_valid(valid_b), .in_last(in_last),
        .in_ready(ready_b), .tx_data(data_b), .tx_enable(en_b), .busy(busy_b),
        .underrun(under_b), .truncated(trunc_b), .frame_count(fc_b)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fc_model [2];
    logic [31:0] crc_table [256];
    byte_q       got, exp_wire;
    int          exp_trunc, exp_under, exp_flush;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference frame: truncate or cut short, pad, table-driven CRC, append FCS.
    task automatic buildExpected(input byte_q payload, input int min_len, input int stop_at);
        int          n, keep;
        logic        bad;
        byte_q       frame;
        logic [31:0] c, fcs;
        n = payload.size();
        exp_trunc = 0; exp_under = 0; exp_flush = 0; bad = 1'b0;
        if (stop_at >= 0) begin
            keep = stop_at; bad = 1'b1; exp_under = 1; exp_flush = n - stop_at;
        end else if (n > MAXL) begin
            keep = MAXL; exp_trunc = 1; exp_flush = n - MAXL;
        end else begin
            keep = n;
        end
        for (int i = 0; i < keep; i++) frame.push_back(payload[i]);
        while (frame.size() < min_len) frame.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (frame[i]) c = (c >> 8) ^ crc_table[c[7:0] ^ frame[i]];
        fcs = bad ? c : ~c;
        exp_wire.delete();
        for (int i = 0; i < 7; i++) exp_wire.push_back(8'h55);
        exp_wire.push_back(8'hD5);
        foreach (frame[i]) exp_wire.push_back(frame[i]);
        for (int i = 0; i < 4; i++) exp_wire.push_back(fcs[8*i +: 8]);
    endtask

    task automatic applyStimulus(input byte_q payload, input int period, input int stop_at,
                                 input string name);
        int   n, idx, en_clk, gap_seen, under_cnt, trunc_cnt, hold_err, ready_err;
        logic gap_active, gap_done, seen_en, done, xfer, adv_now;
        logic [7:0] prev_data;
        logic prev_en;
        n = payload.size();
        idx = 0; en_clk = 0; gap_seen = 0; under_cnt = 0; trunc_cnt = 0;
        hold_err = 0; ready_err = 0;
        gap_active = 1'b0; gap_done = 1'b0; seen_en = 1'b0; done = 1'b0;
        prev_data = obs_data; prev_en = obs_en;
        got.delete();
        for (int t = 0; t < 40000 && !done; t++) begin
            tx_adv = (cyc % period) == 0;
            cyc++;
            if (stop_at >= 0 && idx == stop_at && !gap_done) gap_active = 1'b1;
            in_valid = (idx < n) && !gap_active;
            in_data  = (idx < n) ? payload[idx] : 8'h00;
            in_last  = (idx == n - 1);
            #1;
            xfer    = in_valid && obs_ready;
            adv_now = tx_adv;
            if (obs_ready && !tx_adv) ready_err++;
            @(posedge clk125MHz);
            #1;
            if (xfer) idx++;
            if (obs_under) under_cnt++;
            if (obs_trunc) trunc_cnt++;
            if (obs_en) en_clk++;
            if (adv_now) begin
                if (obs_en) begin
                    got.push_back(obs_data);
                    seen_en = 1'b1;
                end else if (seen_en) begin
                    gap_seen++;
                end
            end else if (obs_data !== prev_data || obs_en !== prev_en) begin
                hold_err++;
            end
            prev_data = obs_data;
            prev_en   = obs_en;
            if (gap_active && seen_en && !obs_en) begin
                gap_active = 1'b0;
                gap_done   = 1'b1;
            end
            if (idx == n && seen_en && !obs_busy) done = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput({name, " completed"}, done, 1'b1);
        buildExpected(payload, sel0 ? 0 : 60, stop_at);
        fc_model[sel0] = (fc_model[sel0] + 1) & 16'hFFFF;
        checkOutput({name, " length"}, got.size(), exp_wire.size());
        for (int i = 0; i < got.size() && i < exp_wire.size(); i++) begin
            checkOutput($sformatf("%s byte%0d", name, i), got[i], exp_wire[i]);
            if (got[i] !== exp_wire[i]) break;
        end
        checkOutput({name, " enable clocks"}, en_clk, period * exp_wire.size());
        checkOutput({name, " idle advances"}, gap_seen, IFG + exp_flush);
        checkOutput({name, " underrun pulses"}, under_cnt, exp_under);
        checkOutput({name, " truncated pulses"}, trunc_cnt, exp_trunc);
        checkOutput({name, " hold violations"}, hold_err, 0);
        checkOutput({name, " ready off-advance"}, ready_err, 0);
        checkOutput({name, " frame_count"}, obs_fc, fc_model[sel0]);
    endtask

    function automatic byte_q randomBytes(input int n);
        byte_q q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    initial begin
        byte_q p, p64;
        string s;
        logic [31:0] c;
        logic [7:0]  g;
        int len, per, stop;

        for (int i = 0; i < 256; i++) begin
            c = i;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_table[i] = c;
        end
        fc_model[0] = 0; fc_model[1] = 0;
        sel0 = 1'b0; tx_adv = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        resetn = 1'b0;
        #3;
        checkOutput("reset tx_enable", en_a, 1'b0);
        checkOutput("reset tx_data", data_a, 8'h00);
        checkOutput("reset busy", busy_a, 1'b0);
        checkOutput("reset in_ready", ready_a, 1'b0);
        checkOutput("reset underrun", under_a, 1'b0);
        checkOutput("reset truncated", trunc_a, 1'b0);
        checkOutput("reset frame_count", fc_a, 16'd0);
        @(negedge clk125MHz);
        resetn = 1'b1;
        @(posedge clk125MHz);
        #1;

        // Known-answer frame on the unpadded instance.
        sel0 = 1'b1;
        s = "123456789";
        p.delete();
        for (int i = 0; i < s.len(); i++) p.push_back(s[i]);
        applyStimulus(p, 1, -1, "t1_check");
        for (int i = 0; i < 4; i++) begin
            c = 32'hCBF43926;
            g = (got.size() == 21) ? got[17 + i] : 8'h00;
            checkOutput($sformatf("t1 fcs byte%0d", i), g, c[8*i +: 8]);
        end

        sel0 = 1'b0;
        applyStimulus(randomBytes(14), 1, -1, "t2_pad");
        p64 = randomBytes(64);
        applyStimulus(p64, 1, -1, "t3_full_rate");
        applyStimulus(p64, 10, -1, "t3_slow_rate");
        applyStimulus(randomBytes(100), 1, 20, "t4_underrun");
        applyStimulus(randomBytes(1600), 1, -1, "t5_truncate");

        // Reset during the payload abandons the frame at once.
        for (int i = 0; i < 30; i++) begin
            tx_adv = 1'b1; in_valid = 1'b1; in_last = 1'b0;
            in_data = 8'($urandom_range(0, 255));
            @(posedge clk125MHz);
            #1;
        end
        checkOutput("t6 enable before reset", en_a, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t6 tx_enable", en_a, 1'b0);
        checkOutput("t6 busy", busy_a, 1'b0);
        checkOutput("t6 frame_count", fc_a, 16'd0);
        in_valid = 1'b0; tx_adv = 1'b0;
        fc_model[0] = 0; fc_model[1] = 0;
        @(negedge clk125MHz);
        resetn = 1'b1;
        @(posedge clk125MHz);
        #1;
        applyStimulus(randomBytes(40), 1, -1, "t6_after_reset");

        for (int r = 0; r < 8; r++) begin
            len  = $urandom_range(1, 130);
            per  = ($urandom_range(0, 3) == 0) ? 3 : 1;
            stop = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            sel0 = 1'($urandom_range(0, 1));
            applyStimulus(randomBytes(len), per, stop, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
